// File: rtl/keypad_matrix_emulator_if.sv
// Command interface of the keypad emulator.
//   cmd_valid/cmd_row/cmd_col : press request from the controller (master)
//   cmd_ready                 : emulator idle and accepting a command
//   busy                      : key sequence in progress
//   done                      : one-cycle pulse when a sequence completes
interface keypad_matrix_emulator_if;
  logic       cmd_valid;
  logic [1:0] cmd_row;
  logic [1:0] cmd_col;
  logic       cmd_ready;
  logic       busy;
  logic       done;

  modport master (output cmd_valid, cmd_row, cmd_col, input cmd_ready, busy, done);
  modport slave  (input cmd_valid, cmd_row, cmd_col, output cmd_ready, busy, done);
endinterface

// File: rtl/keypad_matrix_emulator.sv
// 4x4 membrane keypad emulator: responder end of a column-scan / row-sense
// matrix. Presses one commanded key with deterministic contact bounce on press
// and release, a hold time and a post-release gap.
//   clk     : system clock
//   rst     : asynchronous reset, active low
//   col_in  : column lines from the scanner, active high
//   row_out : row lines to the debouncers, active high, registered
//   cmd     : command interface (slave side)
module keypad_matrix_emulator #(
  parameter int BOUNCE_PERIOD  = 16,
  parameter int BOUNCE_TOGGLES = 6,
  parameter int HOLD_CYCLES    = 50000,
  parameter int GAP_CYCLES     = 50000,
  parameter int CNT_W          = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               col_in,
  output logic [3:0]               row_out,
  keypad_matrix_emulator_if.slave  cmd
);

  localparam logic [2:0] IDLE           = 3'd0;
  localparam logic [2:0] PRESS_BOUNCE   = 3'd1;
  localparam logic [2:0] HOLD           = 3'd2;
  localparam logic [2:0] RELEASE_BOUNCE = 3'd3;
  localparam logic [2:0] GAP            = 3'd4;

  localparam logic [CNT_W-1:0] PER_M1  = CNT_W'(BOUNCE_PERIOD - 1);
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TOGS    = CNT_W'(BOUNCE_TOGGLES);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // cycles left until the next phase event
  logic [CNT_W-1:0] tog_q, tog_d;     // bounce events done in the current burst
  logic             contact_q, contact_d;
  logic [1:0]       key_row_q, key_row_d;
  logic [1:0]       key_col_q, key_col_d;
  logic             rdy_q;
  logic             done_q, done_d;
  logic [3:0]       row_q, row_d;
  logic             tick, accept, bounce_end;

  assign tick   = (cnt_q == '0);
  assign accept = cmd.cmd_valid && rdy_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tog_d      = tog_q;
    contact_d  = contact_q;
    key_row_d  = key_row_q;
    key_col_d  = key_col_q;
    done_d     = 1'b0;
    bounce_end = 1'b0;
    case (state_q)
      IDLE: begin
        contact_d = 1'b0;
        if (accept) begin
          // Event 0 of the press burst fires on the next edge, so contact
          // closes one cycle after the accept edge.
          state_d   = PRESS_BOUNCE;
          cnt_d     = '0;
          tog_d     = '0;
          key_row_d = cmd.cmd_row;
          key_col_d = cmd.cmd_col;
        end
      end
      PRESS_BOUNCE: begin
        if (tick) begin
          // Event 0 closes the contact; events 1..T toggle it.
          contact_d = (tog_q == '0) ? 1'b1 : ~contact_q;
          if (tog_q == TOGS) begin
            state_d = HOLD;
            cnt_d   = HOLD_M1;
          end else begin
            tog_d = tog_q + 1'b1;
            cnt_d = PER_M1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          // Opening the contact here is event 0 of the release burst.
          contact_d = 1'b0;
          if (TOGS == '0) begin
            bounce_end = 1'b1;
          end else begin
            state_d = RELEASE_BOUNCE;
            tog_d   = CNT_W'(1);
            cnt_d   = PER_M1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RELEASE_BOUNCE: begin
        if (tick) begin
          contact_d = ~contact_q;
          if (tog_q == TOGS) begin
            bounce_end = 1'b1;
          end else begin
            tog_d = tog_q + 1'b1;
            cnt_d = PER_M1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        contact_d = 1'b0;
      end
    endcase
    // A zero-length gap skips the GAP state entirely.
    if (bounce_end) begin
      if (GAP_CYCLES == 0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = GAP;
        cnt_d   = GAP_M1;
      end
    end
  end

  // Row drive: only the latched row, gated by the latched column line.
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign row_d[r] = contact_q && (key_row_q == 2'(r)) && col_in[key_col_q];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tog_q     <= '0;
      contact_q <= 1'b0;
      key_row_q <= 2'd0;
      key_col_q <= 2'd0;
      rdy_q     <= 1'b0;
      done_q    <= 1'b0;
      row_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tog_q     <= tog_d;
      contact_q <= contact_d;
      key_row_q <= key_row_d;
      key_col_q <= key_col_d;
      // Registered so ready stays low in reset and rises on the first edge after.
      rdy_q     <= (state_d == IDLE);
      done_q    <= done_d;
      row_q     <= row_d;
    end
  end

  assign row_out       = row_q;
  assign cmd.cmd_ready = rdy_q;
  assign cmd.busy      = (state_q != IDLE);
  assign cmd.done      = done_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
module tb_keypad_matrix_emulator;
  localparam int P   = 4;
  localparam int T   = 2;
  localparam int H   = 20;
  localparam int G   = 8;
  localparam int LEN = 1 + 2*P*T + H + G;   // accept edge to done cycle

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] col0 = 4'hF;
  logic [3:0] row0;
  int         cyc = 0;
  int         ntests = 0;
  int         nfail = 0;
  int         col_mode = 0;       // 0 constant, 1 rotating one-hot, 2 random
  logic [3:0] col_const = 4'hF;

  keypad_matrix_emulator_if k_if ();
  keypad_matrix_emulator_if k0 ();

  keypad_matrix_emulator #(.BOUNCE_PERIOD(P), .BOUNCE_TOGGLES(T), .HOLD_CYCLES(H),
                           .GAP_CYCLES(G), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out), .cmd(k_if));

  keypad_matrix_emulator #(.BOUNCE_PERIOD(P), .BOUNCE_TOGGLES(0), .HOLD_CYCLES(H),
                           .GAP_CYCLES(G), .CNT_W(24)) dut0 (
    .clk(clk), .rst(rst), .col_in(col0), .row_out(row0), .cmd(k0));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference contact level n cycles after the accept edge, from the timing rules.
  function automatic bit contact_at(input int n);
    int r;
    if (n < 1) return 1'b0;
    if (n < 1 + P*T) return ((n - 1) / P) % 2 == 0;
    r = 1 + P*T + H;
    if (n < r) return 1'b1;
    if (n < r + P*T) return ((n - r) / P) % 2 == 1;
    return 1'b0;
  endfunction

  typedef struct { logic [1:0] r; logic [1:0] c; int acc; } rec_t;
  rec_t sbq[$];

  // Column driver.
  initial begin
    col_in = 4'hF;
    forever begin
      @(posedge clk); #2;
      case (col_mode)
        0: col_in = col_const;
        1: col_in = ($countones(col_in) == 1) ? {col_in[2:0], col_in[3]} : 4'b0001;
        default: col_in = 4'($urandom);
      endcase
    end
  end

  // Stimulus side of the scoreboard: each handshake pushes the expected sequence.
  initial forever begin
    @(negedge clk);
    if (rst && k_if.cmd_valid && k_if.cmd_ready)
      sbq.push_back('{r: k_if.cmd_row, c: k_if.cmd_col, acc: cyc + 1});
  end

  // Monitor: compares every cycle's outputs against the active expected sequence.
  initial begin
    logic [3:0] pcol, exp_row;
    bit prst, exp_busy, exp_done, exp_rdy;
    int n;
    pcol = 4'd0; prst = 1'b0;
    forever begin
      @(negedge clk);
      exp_row = 4'd0; exp_busy = 1'b0; exp_done = 1'b0;
      if (!rst) sbq.delete();
      else if (sbq.size() > 0) begin
        n = cyc - sbq[0].acc;
        exp_busy = (n >= 0) && (n < LEN);
        exp_done = (n == LEN);
        if (contact_at(n - 1) && pcol[sbq[0].c]) exp_row[sbq[0].r] = 1'b1;
      end
      exp_rdy = rst && prst && !exp_busy;
      chk("row_out", 32'(row_out), 32'(exp_row));
      chk("busy", 32'(k_if.busy), 32'(exp_busy));
      chk("done", 32'(k_if.done), 32'(exp_done));
      chk("cmd_ready", 32'(k_if.cmd_ready), 32'(exp_rdy));
      if (exp_done) void'(sbq.pop_front());
      pcol = col_in;
      prst = rst;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_ready(output int hs);
    hs = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (k_if.cmd_ready) begin hs = cyc; break; end
    end
    if (hs < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(output int dn);
    dn = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (k_if.done) begin dn = cyc; break; end
    end
    if (dn < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    int hs, dn;
    step();
    k_if.cmd_valid = 1'b1; k_if.cmd_row = r; k_if.cmd_col = c;
    wait_ready(hs);
    step();
    k_if.cmd_valid = 1'b0;
    wait_done(dn);
    chk("seq_len", 32'(dn - (hs + 1)), 32'(LEN));
  endtask

  initial begin
    int hs, hs2, dn, hi, rises, first_hi, dn0;
    logic prev;
    k_if.cmd_valid = 1'b1; k_if.cmd_row = 2'd0; k_if.cmd_col = 2'd0;
    k0.cmd_valid = 1'b0; k0.cmd_row = 2'd0; k0.cmd_col = 2'd0;

    // Reset with columns all high and a pending request.
    repeat (4) step();
    @(negedge clk);
    chk("rst_row", 32'(row_out), 0);
    chk("rst_ready", 32'(k_if.cmd_ready), 0);
    chk("rst_busy", 32'(k_if.busy), 0);
    step();
    rst = 1'b1; k_if.cmd_valid = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", 32'(k_if.cmd_ready), 0);
    @(negedge clk);
    chk("ready_after_edge", 32'(k_if.cmd_ready), 1);

    // Basic press of key (1,2) with column 2 held high.
    col_const = 4'b0100; col_mode = 0;
    press(2'd1, 2'd2);

    // Column gating with a rotating one-hot column.
    col_mode = 1;
    press(2'd1, 2'd2);

    // Back-to-back with request held and key scrambled mid-sequence.
    col_mode = 2;
    step();
    k_if.cmd_valid = 1'b1; k_if.cmd_row = 2'd3; k_if.cmd_col = 2'd0;
    wait_ready(hs);
    for (int i = 0; i < 30; i++) begin
      step();
      k_if.cmd_row = 2'($urandom); k_if.cmd_col = 2'($urandom);
    end
    step();
    k_if.cmd_row = 2'd3; k_if.cmd_col = 2'd0;
    wait_ready(hs2);
    chk("b2b_done_with_ready", 32'(k_if.done), 1);
    chk("b2b_spacing", 32'(hs2 - (hs + 1)), 32'(LEN));
    step();
    k_if.cmd_valid = 1'b0;
    wait_done(dn);
    chk("b2b_seq_len", 32'(dn - (hs2 + 1)), 32'(LEN));

    // Clean edges: T=0 gives a single contact pulse of H cycles.
    step();
    k0.cmd_valid = 1'b1; k0.cmd_row = 2'd2; k0.cmd_col = 2'd3;
    hs = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (k0.cmd_ready) begin hs = cyc; break; end
    end
    if (hs < 0) chk("t0_accept_timeout", 0, 1);
    step();
    k0.cmd_valid = 1'b0;
    hi = 0; rises = 0; first_hi = -1; dn0 = -1; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (row0 == 4'b0100) begin
        hi++;
        if (!prev) rises++;
        if (first_hi < 0) first_hi = cyc;
      end else if (row0 != 4'd0) chk("t0_row_other", 32'(row0), 0);
      prev = (row0 == 4'b0100);
      if (k0.done) dn0 = cyc;
    end
    chk("t0_pulse_len", 32'(hi), 32'(H));
    chk("t0_pulse_count", 32'(rises), 1);
    chk("t0_first_row", 32'(first_hi - (hs + 1)), 2);
    chk("t0_done", 32'(dn0 - (hs + 1)), 32'(1 + H + G));

    // Reset in the middle of HOLD.
    col_const = 4'hF; col_mode = 0;
    step();
    k_if.cmd_valid = 1'b1; k_if.cmd_row = 2'd2; k_if.cmd_col = 2'd1;
    wait_ready(hs);
    step();
    k_if.cmd_valid = 1'b0;
    repeat (14) step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_row", 32'(row_out), 0);
    chk("midrst_busy", 32'(k_if.busy), 0);
    chk("midrst_done", 32'(k_if.done), 0);
    repeat (3) step();
    rst = 1'b1;
    press(2'd0, 2'd3);

    // Randomized presses with random column activity.
    col_mode = 2;
    for (int i = 0; i < 6; i++) press(2'($urandom), 2'($urandom));

    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/keypad_matrix_emulator.md
# keypad_matrix_emulator

Synthesizable model of a 4x4 membrane keypad: the responder end of the column-scan / row-sense interface. It watches the column lines driven by the keypad scanner and drives the row lines exactly as a physical keypad would. It presses one commanded key with deterministic contact bounce on press and release, a programmable hold time, and a post-release gap. It is used for FPGA loopback bring-up and as the stimulus source in system benches of the keypad-to-display path.

## Interface

Parameters:

- BOUNCE_PERIOD, default 16: cycles between contact toggles during bounce; must be >= 1.
- BOUNCE_TOGGLES, default 6: number of contact toggles in each bounce burst; must be even; 0 means a clean edge.
- HOLD_CYCLES, default 50000: cycles the contact stays solidly closed after the press bounce; must be >= 1.
- GAP_CYCLES, default 50000: cycles of open contact after the release bounce before the next command is accepted; must be >= 0.
- CNT_W, default 24: width of internal counters; must hold max(BOUNCE_PERIOD, HOLD_CYCLES, GAP_CYCLES).

Ports:

- clk  input  1: system clock.
- rst  input  1: asynchronous, active-low reset.
- col_in  input  4: column lines from the scanner; active-high, bit c = column c.
- row_out  output  4: row lines to the debouncers; active-high, bit r = row r.
- cmd_valid  input  1: request to press the key given by cmd_row and cmd_col.
- cmd_row  input  2: row index of the key to press.
- cmd_col  input  2: column index of the key to press.
- cmd_ready  output  1: emulator is idle and accepts a command.
- busy  output  1: a key sequence is in progress.
- done  output  1: one-cycle pulse when a sequence completes.

## Operation

- Reset values:
  - row_out = 0, cmd_ready = 0, busy = 0, done = 0.
  - Internal contact = 0; state = IDLE.
  - cmd_ready rises on the first clk edge after rst goes high.
- Handshake:
  - A command is accepted on a rising edge where cmd_valid && cmd_ready.
  - cmd_row and cmd_col are latched on that edge.
  - cmd_ready drops on the same edge and stays low until the sequence finishes.
  - cmd_valid is ignored while cmd_ready is 0. No queueing is performed.
- FSM states:
  - IDLE: contact = 0, cmd_ready = 1, busy = 0. Goes to PRESS_BOUNCE on accept.
  - PRESS_BOUNCE: contact is set to 1 on entry, then toggles every BOUNCE_PERIOD cycles, BOUNCE_TOGGLES times. It therefore ends closed. Goes to HOLD. If BOUNCE_TOGGLES = 0, it goes straight to HOLD with contact = 1.
  - HOLD: contact = 1 for HOLD_CYCLES cycles. Goes to RELEASE_BOUNCE.
  - RELEASE_BOUNCE: contact is set to 0 on entry, then toggles every BOUNCE_PERIOD cycles, BOUNCE_TOGGLES times. It therefore ends open. Goes to GAP.
  - GAP: contact = 0 for GAP_CYCLES cycles, then goes to IDLE. If GAP_CYCLES = 0, it goes directly to IDLE.
- busy = 1 in every state except IDLE.
- done pulses high for exactly the first cycle back in IDLE after a sequence; cmd_ready is high in that same cycle.
- Row drive, registered: on each edge, row_out[r] <= contact && (r == latched row) && col_in[latched col]. All other row bits are 0.
- Only one key is ever modelled, so there is no ghosting or multi-key behaviour.
- Reset mid-operation: the sequence is abandoned immediately, row_out = 0, the latched key is discarded, and no done pulse is produced.
- col_in with several bits high: the row is still driven whenever the selected column bit is high. The other column bits are don't-care.

## Timing

- Let edge 0 be the accept edge, P = BOUNCE_PERIOD, T = BOUNCE_TOGGLES, H = HOLD_CYCLES, G = GAP_CYCLES.
- Contact is 1 from cycle 1.
- Press toggles occur at cycles 1+P·k, for k = 1..T.
- Hold spans cycles 1+P·T through P·T+H.
- Release begins at cycle R = 1+P·T+H with contact 0. Release toggles occur at R+P·k, for k = 1..T.
- GAP spans cycles R+P·T through R+P·T+G−1.
- done and cmd_ready are high at cycle R+P·T+G.
- Sequence length from accept to done is 1+2·P·T+H+G cycles.
- row_out lags contact && col_in by exactly one cycle. There is no combinational path from col_in to row_out.

## Test plan

Unless stated otherwise, parameters are P=4, T=2, H=20, G=8.

- Reset: hold rst=0 while driving col_in=4'hF and cmd_valid=1. Required: row_out=0, cmd_ready=0, busy=0 throughout. cmd_ready=1 one edge after release.
- Basic press of key (1,2) with col_in=4'b0100 constant, accepted at edge 0. Required:
  - row_out=4'b0010 during cycles 2–5, 10–29 and 34–37.
  - row_out=0 during cycles 6–9, 30–33 and 38 onward.
  - done=1 only at cycle 45.
- Column gating: the same command, with col_in rotating one-hot every cycle. Required: row_out[1] is high only in the cycle after col_in=4'b0100 while contact=1; the other row bits stay 0.
- Back-to-back and busy-ignore:
  - Hold cmd_valid=1 continuously with key (3,0) and change cmd_row/cmd_col mid-sequence. Required: the changes are ignored, and the second sequence is accepted at cycle 45, the same cycle as done.
  - With T=0, the contact is a clean 20-cycle pulse.
- Reset mid-HOLD: assert rst at cycle 15. Required: row_out=0, busy=0 and done=0 immediately. After release, cmd_ready=1 and a new command runs a full, correct sequence.
